// File: rtl/seg_scan_pkg.sv
// Shared types and 7-segment patterns ({g,f,e,d,c,b,a}, active-high) for the scan controller.
package seg_scan_pkg;

  typedef logic [3:0] digit_t;

  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_A     = 7'h77;
  localparam logic [6:0] SEG_B     = 7'h7C;
  localparam logic [6:0] SEG_C     = 7'h39;
  localparam logic [6:0] SEG_D     = 7'h5E;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_F     = 7'h71;
  localparam logic [6:0] SEG_BLANK = 7'h00;

  function automatic logic [6:0] seg_pattern(input digit_t v);
    case (v)
      4'h0:    seg_pattern = SEG_0;
      4'h1:    seg_pattern = SEG_1;
      4'h2:    seg_pattern = SEG_2;
      4'h3:    seg_pattern = SEG_3;
      4'h4:    seg_pattern = SEG_4;
      4'h5:    seg_pattern = SEG_5;
      4'h6:    seg_pattern = SEG_6;
      4'h7:    seg_pattern = SEG_7;
      4'h8:    seg_pattern = SEG_8;
      4'h9:    seg_pattern = SEG_9;
      4'hA:    seg_pattern = SEG_A;
      4'hB:    seg_pattern = SEG_B;
      4'hC:    seg_pattern = SEG_C;
      4'hD:    seg_pattern = SEG_D;
      4'hE:    seg_pattern = SEG_E;
      default: seg_pattern = SEG_F;
    endcase
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_seg7_decoder.sv
// Combinational hex digit to 7-segment pattern decoder.
import seg_scan_pkg::*;

module seg7_decoder (
  input  digit_t     d,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg_pattern(d);
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 7-segment scan controller with prescaler, per-frame snapshot and PWM brightness.
// Optional leading-zero blanking is built when SEG_SCAN_LZB_EN is defined.
import seg_scan_pkg::*;

module seg_scan_ctrl #(
  parameter int N_DIGITS = 6,
  parameter int DIV_W    = 10,
  parameter int BRT_W    = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] digits,
  input  logic [BRT_W-1:0]      bright,
  output logic [N_DIGITS-1:0]   seg_sel,
  output logic [6:0]            seg,
  output logic [3:0]            d,
  output logic                  frame_done
);

  localparam int IDX_W = $clog2(N_DIGITS);

  logic [DIV_W-1:0]      prescaler;
  logic [IDX_W-1:0]      idx, idx_next;
  logic [4*N_DIGITS-1:0] snapshot;
  logic                  tick, last, on, visible, cur_blank;
  digit_t                d_next;
  logic [N_DIGITS-1:0]   sel_next;
  logic [6:0]            seg_dec;

  assign tick = en && (prescaler == '1);
  assign last = (idx == IDX_W'(N_DIGITS - 1));
  assign on   = (bright == '1) || (prescaler[DIV_W-1 -: BRT_W] < bright);

  // Out-of-range idx values fall back to 0 on the next tick.
  always_comb begin
    idx_next = idx;
    if (tick) begin
      if (idx >= IDX_W'(N_DIGITS - 1)) idx_next = '0;
      else                             idx_next = idx + IDX_W'(1);
    end
  end

  // Compare-based select keeps unreachable idx values from indexing past the snapshot.
  always_comb begin
    d_next   = '0;
    sel_next = '0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        d_next                  = snapshot[4*i +: 4];
        sel_next[N_DIGITS-1-i]  = 1'b1;
      end
    end
  end

`ifdef SEG_SCAN_LZB_EN
  logic [N_DIGITS-1:0] blank;

  // A digit is blanked while every digit up to and including it is zero; the last digit always shows.
  always_comb begin : lzb
    logic seen;
    seen      = 1'b0;
    blank     = '0;
    cur_blank = 1'b0;
    for (int unsigned i = 0; i < N_DIGITS; i++) begin
      if (snapshot[4*i +: 4] != '0) seen = 1'b1;
      blank[i] = !seen && (i != N_DIGITS - 1);
      if (idx == IDX_W'(i)) cur_blank = blank[i];
    end
  end
`else
  assign cur_blank = 1'b0;
`endif

  assign visible = en && on && !cur_blank;

  seg7_decoder u_dec (
    .d   (d_next),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      prescaler  <= '0;
      idx        <= '0;
      snapshot   <= '0;
      seg_sel    <= '0;
      seg        <= SEG_BLANK;
      d          <= '0;
      frame_done <= 1'b0;
    end else begin
      if (en) prescaler <= prescaler + DIV_W'(1);
      idx <= idx_next;
      if (tick && last) snapshot <= digits;
      frame_done <= tick && last;
      d          <= d_next;
      seg        <= visible ? seg_dec : SEG_BLANK;
      seg_sel    <= visible ? sel_next : '0;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (N_DIGITS=6, DIV_W=4, BRT_W=2); define SEG_SCAN_LZB_EN to cover blanking.
module tb_seg_scan_ctrl;

  localparam int N  = 6;
  localparam int DW = 4;
  localparam int BW = 2;
  localparam int DP = 1 << DW;   // cycles per digit
  localparam int FP = DP * N;    // cycles per frame

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic [23:0]   digits = '0;
  logic [BW-1:0] bright = '0;
  logic [N-1:0]  seg_sel;
  logic [6:0]    seg;
  logic [3:0]    d;
  logic          frame_done;

  seg_scan_ctrl #(.N_DIGITS(N), .DIV_W(DW), .BRT_W(BW)) dut (
    .clk        (clk),
    .reset      (reset),
    .en         (en),
    .digits     (digits),
    .bright     (bright),
    .seg_sel    (seg_sel),
    .seg        (seg),
    .d          (d),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [6:0] dec_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  // Reference model: position in the frame is the count of enabled cycles since reset.
  int          ecount = 0;
  logic [23:0] snap = '0;
  logic [N-1:0] exp_sel = '0;
  logic [6:0]  exp_seg = '0;
  logic [3:0]  exp_d = '0;
  logic        exp_fd = 1'b0;

  function automatic logic model_blank(input logic [23:0] s, input int k);
`ifdef SEG_SCAN_LZB_EN
    if (k == N - 1) return 1'b0;
    for (int j = 0; j <= k; j++) if (((s >> (4*j)) & 24'hF) != 0) return 1'b0;
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_update();
    int pres, k;
    logic vis;
    if (!reset) begin
      ecount = 0; snap = '0;
      exp_sel = '0; exp_seg = '0; exp_d = '0; exp_fd = 1'b0;
    end else begin
      pres    = ecount % DP;
      k       = ecount / DP;
      vis     = en && ((bright == 2'd3) || ((pres / 4) < int'(bright))) && !model_blank(snap, k);
      exp_d   = 4'((snap >> (4*k)) & 24'hF);
      exp_seg = vis ? dec_tab[exp_d] : 7'h00;
      exp_sel = vis ? N'(1 << (N - 1 - k)) : '0;
      exp_fd  = en && (ecount == FP - 1);
      if (exp_fd) snap = digits;
      if (en) ecount = (ecount + 1) % FP;
    end
  endtask

  task automatic step();
    model_update();
    @(posedge clk);
    #1;
    tests++;
    if (seg_sel !== exp_sel || seg !== exp_seg || d !== exp_d || frame_done !== exp_fd) begin
      fails++;
      $display("FAIL model @%0t: got sel=%h seg=%h d=%h fd=%b, expected sel=%h seg=%h d=%h fd=%b",
               $time, seg_sel, seg, d, frame_done, exp_sel, exp_seg, exp_d, exp_fd);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_frame();
    int cnt;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (frame_done !== 1'b1 && cnt < 4 * FP);
    if (frame_done !== 1'b1) check_val("frame_timeout", 0, 1);
  endtask

  typedef struct {
    logic [23:0]   digits;
    logic [BW-1:0] bright;
    int            idx;
    logic [N-1:0]  sel;
    logic [6:0]    seg;
    logic [3:0]    d;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [6:0] t1_seg [6];
    int cnt, oncnt, mask;
    int per_dig [6];

    vecs[0] = '{24'hFEDCBA, 2'd3, 0, 6'h20, 7'h77, 4'hA};
    vecs[1] = '{24'hFEDCBA, 2'd3, 5, 6'h01, 7'h71, 4'hF};
    vecs[2] = '{24'hFEDCBA, 2'd1, 2, 6'h08, 7'h39, 4'hC};
    vecs[3] = '{24'h987654, 2'd2, 1, 6'h10, 7'h6D, 4'h5};
    vecs[4] = '{24'h987654, 2'd3, 4, 6'h02, 7'h7F, 4'h8};
    vecs[5] = '{24'h987654, 2'd0, 3, 6'h00, 7'h00, 4'h7};
    vecs[6] = '{24'h3E1B2D, 2'd3, 0, 6'h20, 7'h5E, 4'hD};
    vecs[7] = '{24'h3E1B2D, 2'd1, 2, 6'h08, 7'h7C, 4'hB};
    t1_seg  = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};

    // Test 1: reset and basic scan
    reset = 1'b0; en = 1'b1; bright = 2'd3; digits = 24'h543210;
    steps(3);
    check_val("reset_sel", int'(seg_sel), 0);
    check_val("reset_seg", int'(seg), 0);
    check_val("reset_d", int'(d), 0);
    check_val("reset_fd", int'(frame_done), 0);
    reset = 1'b1;
    wait_frame();
    for (int k = 0; k < N; k++) begin
      for (int c = 0; c < DP; c++) begin
        step();
        if (c == 0 || c == DP - 1) begin
          check_val("t1_sel", int'(seg_sel), 1 << (N - 1 - k));
          check_val("t1_d", int'(d), k);
          check_val("t1_seg", int'(seg), int'(t1_seg[k]));
        end
      end
    end
    check_val("t1_frame_period", int'(frame_done), 1);

    // Test 2: mid-frame data change only shows in the following frame
    steps(40);
    digits = 24'hFFFFFF;
    steps(20);
    check_val("t2_old_d", int'(d), 3);
    wait_frame();
    step();
    check_val("t2_new_seg", int'(seg), 'h71);
    steps(50);
    check_val("t2_new_d", int'(d), 'hF);

    // Test 3: brightness duty
    bright = 2'd1;
    digits = 24'h543210;
    wait_frame();
    oncnt = 0;
    for (int k = 0; k < N; k++) begin
      per_dig[k] = 0;
      for (int c = 0; c < DP; c++) begin
        step();
        if (seg_sel != 0) per_dig[k]++;
      end
      oncnt += per_dig[k];
    end
    check_val("t3_on_dig0", per_dig[0], 4);
    check_val("t3_on_dig5", per_dig[5], 4);
    check_val("t3_on_frame", oncnt, 24);
    bright = 2'd0;
    oncnt = 0;
    for (int i = 0; i < FP; i++) begin
      step();
      if (seg_sel != 0) oncnt++;
    end
    check_val("t3_off_count", oncnt, 0);

    // Test 4: enable gating mid-digit
    bright = 2'd3;
    wait_frame();
    steps(20);
    en = 1'b0;
    step();
    check_val("t4_sel_off", int'(seg_sel), 0);
    check_val("t4_seg_off", int'(seg), 0);
    cnt = 0;
    for (int i = 0; i < 49; i++) begin
      step();
      if (frame_done) cnt++;
    end
    check_val("t4_no_fd", cnt, 0);
    en = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (seg_sel == 6'h10) cnt++;
    end
    check_val("t4_resume_remaining", cnt, 12);

    // Table-driven vectors: one decoded digit per record
    foreach (vecs[v]) begin
      digits = vecs[v].digits;
      bright = vecs[v].bright;
      wait_frame();
      steps(DP * vecs[v].idx + 1);
      check_val("vec_sel", int'(seg_sel), int'(vecs[v].sel));
      check_val("vec_seg", int'(seg), int'(vecs[v].seg));
      check_val("vec_d", int'(d), int'(vecs[v].d));
    end

    // Test 5: reset mid-frame, with a between-edge glitch that must be ignored
    bright = 2'd3;
    digits = 24'h543210;
    wait_frame();
    wait_frame();
    steps(50);
    reset = 1'b0; #3; reset = 1'b1;
    step();
    check_val("t5_glitch_d", int'(d), 3);
    reset = 1'b0;
    step();
    check_val("t5_rst_sel", int'(seg_sel), 0);
    check_val("t5_rst_seg", int'(seg), 0);
    check_val("t5_rst_d", int'(d), 0);
    reset = 1'b1;
    step();
    check_val("t5_restart_sel", int'(seg_sel), 'h20);

`ifdef SEG_SCAN_LZB_EN
    // Test 6: leading-zero blanking
    digits = 24'h000700;
    wait_frame();
    mask = 0;
    for (int i = 0; i < FP; i++) begin
      step();
      mask |= int'(seg_sel);
    end
    check_val("t6_lzb_mask", mask, 'h0F);
    digits = 24'h000000;
    wait_frame();
    mask = 0;
    oncnt = 0;
    for (int i = 0; i < FP; i++) begin
      step();
      mask |= int'(seg_sel);
      if (seg_sel != 0 && seg != 7'h3F) oncnt++;
    end
    check_val("t6_zero_mask", mask, 'h01);
    check_val("t6_zero_seg", oncnt, 0);
`endif

    // Randomized phase against the reference model
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 19) == 0) en = ~en;
      if ($urandom_range(0, 49) == 0) bright = BW'($urandom_range(0, 3));
      if ($urandom_range(0, 29) == 0) digits = 24'($urandom);
      if ($urandom_range(0, 7) == 0) digits[23:12] = '0;
      reset = ($urandom_range(0, 299) != 0);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
